hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 22 ++
 rtl/md_timer.sv | 71 +++++++
 rtl/hazard_unit.sv | 88 ++++++++
 tb/tb_hazard_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared CPU pipeline constants: register/counter widths, multiply/divide timer
// state encoding and the register-match rule used by hazard decode.
package hazard_unit_pkg;

   localparam int REG_W          = 5;
   localparam int CNT_W          = 16;
   localparam int MD_LAT_DEFAULT = 32;
   localparam int MD_CNT_W       = 6;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

   // Register 0 is hardwired to zero, so it never creates a dependency.
   function automatic logic reg_match(input logic [REG_W-1:0] a,
                                      input logic [REG_W-1:0] b);
      return (a == b) && (a != '0);
   endfunction

endpackage

// File: rtl/md_timer.sv
// Multiply/divide occupancy timer: IDLE -> BUSY for MD_LAT cycles -> DONE,
// with a sticky error flag for a start issued while the unit is busy.
module md_timer
   import hazard_unit_pkg::*;
#(
   parameter int MD_LAT = MD_LAT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       MD_Start,
   output logic       MD_Busy,
   output logic       MD_Err,
   output logic [1:0] state
);

   localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MD_LAT - 1);

   md_state_t           state_q, state_d;
   logic [MD_CNT_W-1:0] cnt_q, cnt_d;
   logic                err_q, err_d;

   // NOTE: reset is synchronous, so it lives inside the clocked block and is only seen at an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // NOTE: every always_comb target gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         MD_IDLE: begin
            if (MD_Start) begin
               state_d = MD_BUSY;
               cnt_d   = CNT_LOAD;
            end
         end
         MD_BUSY: begin
            if (MD_Start) err_d = 1'b1;
            if (cnt_q == '0) state_d = MD_DONE;
            else             cnt_d   = cnt_q - MD_CNT_W'(1);
         end
         MD_DONE: begin
            if (MD_Start) begin
               state_d = MD_BUSY;
               cnt_d   = CNT_LOAD;
            end else begin
               state_d = MD_IDLE;
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   // Busy is masked during the reset cycle so an aborted operation drops at once.
   always_comb begin
      MD_Busy = (state_q == MD_BUSY) && !rst;
      MD_Err  = err_q;
      state   = state_q;
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: combinational load-use / branch / HI-LO stall decode,
// taken-branch flush, multiply/divide timer and saturating event counters.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int MD_LAT = MD_LAT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_W-1:0]  IFID_RegRs,
   input  logic [REG_W-1:0]  IFID_RegRt,
   input  logic              IFID_UsesRt,
   input  logic              IFID_Branch,
   input  logic              IFID_UsesHiLo,
   input  logic              IDEX_MemRead,
   input  logic              IDEX_RegWrite,
   input  logic [REG_W-1:0]  IDEX_RegRd,
   input  logic              EXMEM_MemRead,
   input  logic [REG_W-1:0]  EXMEM_RegRd,
   input  logic              Branch_Taken,
   input  logic              MD_Start,
   output logic              PC_Write,
   output logic              IFID_Write,
   output logic              IFID_Flush,
   output logic              IDEX_Flush,
   output logic              MD_Busy,
   output logic              MD_Err,
   output logic [CNT_W-1:0]  Stall_Cnt,
   output logic [CNT_W-1:0]  Flush_Cnt
);

   logic [1:0]       md_state;
   logic             ex_src_match, mem_src_match;
   logic             load_use, branch_alu, branch_load, hilo;
   logic             stall, flush;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   md_timer #(.MD_LAT(MD_LAT)) u_md_timer (
      .clk      (clk),
      .rst      (rst),
      .MD_Start (MD_Start),
      .MD_Busy  (MD_Busy),
      .MD_Err   (MD_Err),
      .state    (md_state)
   );

   always_comb begin
      ex_src_match  = reg_match(IDEX_RegRd, IFID_RegRs) ||
                      (IFID_UsesRt && reg_match(IDEX_RegRd, IFID_RegRt));
      mem_src_match = reg_match(EXMEM_RegRd, IFID_RegRs) ||
                      (IFID_UsesRt && reg_match(EXMEM_RegRd, IFID_RegRt));
      load_use      = IDEX_MemRead && ex_src_match;
      branch_alu    = IFID_Branch && IDEX_RegWrite && !IDEX_MemRead && ex_src_match;
      branch_load   = IFID_Branch && ((EXMEM_MemRead && mem_src_match) || load_use);
      hilo          = IFID_UsesHiLo && ((md_state == MD_BUSY) || MD_Start);
      // The reset cycle always presents idle pipeline controls.
      stall         = (load_use || branch_alu || branch_load || hilo) && !rst;
      flush         = Branch_Taken && !stall && !rst;
   end

   always_comb begin
      PC_Write   = !stall;
      IFID_Write = !stall;
      IDEX_Flush = stall;
      IFID_Flush = flush;
      Stall_Cnt  = stall_cnt_q;
      Flush_Cnt  = flush_cnt_q;
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: expected controls are queued as each
// cycle is driven and compared against the DUT mid-cycle.
module tb_hazard_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  IFID_RegRs, IFID_RegRt, IDEX_RegRd, EXMEM_RegRd;
   logic        IFID_UsesRt, IFID_Branch, IFID_UsesHiLo;
   logic        IDEX_MemRead, IDEX_RegWrite, EXMEM_MemRead;
   logic        Branch_Taken, MD_Start;
   logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, MD_Busy, MD_Err;
   logic [15:0] Stall_Cnt, Flush_Cnt;

   typedef struct {
      string       name;
      logic [5:0]  ctl;
      logic [15:0] stall_cnt;
      logic [15:0] flush_cnt;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fails  = 0;
   logic [15:0] m_stall  = 16'd0;
   logic [15:0] m_flush  = 16'd0;

   hazard_unit #(.MD_LAT(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .IFID_RegRs    (IFID_RegRs),
      .IFID_RegRt    (IFID_RegRt),
      .IFID_UsesRt   (IFID_UsesRt),
      .IFID_Branch   (IFID_Branch),
      .IFID_UsesHiLo (IFID_UsesHiLo),
      .IDEX_MemRead  (IDEX_MemRead),
      .IDEX_RegWrite (IDEX_RegWrite),
      .IDEX_RegRd    (IDEX_RegRd),
      .EXMEM_MemRead (EXMEM_MemRead),
      .EXMEM_RegRd   (EXMEM_RegRd),
      .Branch_Taken  (Branch_Taken),
      .MD_Start      (MD_Start),
      .PC_Write      (PC_Write),
      .IFID_Write    (IFID_Write),
      .IFID_Flush    (IFID_Flush),
      .IDEX_Flush    (IDEX_Flush),
      .MD_Busy       (MD_Busy),
      .MD_Err        (MD_Err),
      .Stall_Cnt     (Stall_Cnt),
      .Flush_Cnt     (Flush_Cnt)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      IFID_RegRs    = 5'd0;
      IFID_RegRt    = 5'd0;
      IFID_UsesRt   = 1'b0;
      IFID_Branch   = 1'b0;
      IFID_UsesHiLo = 1'b0;
      IDEX_MemRead  = 1'b0;
      IDEX_RegWrite = 1'b0;
      IDEX_RegRd    = 5'd0;
      EXMEM_MemRead = 1'b0;
      EXMEM_RegRd   = 5'd0;
      Branch_Taken  = 1'b0;
      MD_Start      = 1'b0;
   endtask

   // One clock cycle with the inputs already driven: queue the expectation,
   // compare at the falling edge, advance the counter model, cross the edge.
   task automatic step(input string name, input bit e_stall, input bit e_flush,
                       input bit e_busy, input bit e_err, input bit chk = 1'b1);
      exp_t e, got;
      if (chk) begin
         e.name      = name;
         e.ctl       = {~e_stall, ~e_stall, e_flush, e_stall, e_busy, e_err};
         e.stall_cnt = m_stall;
         e.flush_cnt = m_flush;
         sb.push_back(e);
      end
      @(negedge clk);
      if (chk) begin
         got = sb.pop_front();
         n_checks++;
         if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, MD_Busy, MD_Err} !== got.ctl) begin
            n_fails++;
            $display("FAIL %s ctl{pcw,ifw,iff,idf,busy,err} got %b want %b", got.name,
                     {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, MD_Busy, MD_Err}, got.ctl);
         end
         n_checks++;
         if (Stall_Cnt !== got.stall_cnt) begin
            n_fails++;
            $display("FAIL %s Stall_Cnt got %h want %h", got.name, Stall_Cnt, got.stall_cnt);
         end
         n_checks++;
         if (Flush_Cnt !== got.flush_cnt) begin
            n_fails++;
            $display("FAIL %s Flush_Cnt got %h want %h", got.name, Flush_Cnt, got.flush_cnt);
         end
      end
      if (rst) begin
         m_stall = 16'd0;
         m_flush = 16'd0;
      end else begin
         if (e_stall && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
         if (e_flush && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      IDEX_MemRead = 1'b1; IDEX_RegRd = 5'd5; IFID_RegRs = 5'd5;
      Branch_Taken = 1'b1; MD_Start = 1'b1; IFID_UsesHiLo = 1'b1;
      step("reset_cycle", 0, 0, 0, 0);
      rst = 1'b0;
      clear_inputs();
      step("post_reset_idle", 0, 0, 0, 0);
      step("post_reset_idle2", 0, 0, 0, 0);
   endtask

   task automatic test_load_use();
      IDEX_MemRead = 1'b1; IDEX_RegRd = 5'd5; IFID_RegRs = 5'd5;
      step("load_use_rs", 1, 0, 0, 0);
      clear_inputs();
      step("load_use_released", 0, 0, 0, 0);
   endtask

   task automatic test_zero_reg();
      IDEX_MemRead = 1'b1; IDEX_RegRd = 5'd0; IFID_RegRs = 5'd0;
      step("zero_reg_no_match", 0, 0, 0, 0);
      IDEX_RegRd = 5'd7; IFID_RegRs = 5'd1; IFID_RegRt = 5'd7; IFID_UsesRt = 1'b0;
      step("rt_unused_no_stall", 0, 0, 0, 0);
      IFID_UsesRt = 1'b1;
      step("rt_used_stall", 1, 0, 0, 0);
      clear_inputs();
   endtask

   task automatic test_branch_alu();
      IDEX_RegWrite = 1'b1; IDEX_RegRd = 5'd3; IFID_RegRt = 5'd3; IFID_UsesRt = 1'b1;
      step("alu_no_branch", 0, 0, 0, 0);
      IFID_Branch = 1'b1;
      step("branch_alu_stall", 1, 0, 0, 0);
      clear_inputs();
   endtask

   task automatic test_branch_load();
      IFID_Branch = 1'b1; IFID_RegRs = 5'd8;
      IDEX_MemRead = 1'b1; IDEX_RegRd = 5'd8;
      step("branch_load_ex", 1, 0, 0, 0);
      IDEX_MemRead = 1'b0; IDEX_RegRd = 5'd0;
      EXMEM_MemRead = 1'b1; EXMEM_RegRd = 5'd8; Branch_Taken = 1'b1;
      step("branch_load_mem_taken_ignored", 1, 0, 0, 0);
      EXMEM_MemRead = 1'b0; EXMEM_RegRd = 5'd0;
      step("branch_taken_flush", 0, 1, 0, 0);
      clear_inputs();
      step("after_flush_idle", 0, 0, 0, 0);
   endtask

   task automatic test_md();
      IFID_UsesHiLo = 1'b1; MD_Start = 1'b1;
      step("md_start_hilo", 1, 0, 0, 0);
      MD_Start = 1'b0;
      for (int i = 0; i < 32; i++) step($sformatf("md_busy_%0d", i), 1, 0, 1, 0);
      step("md_done_hilo", 0, 0, 0, 0);
      step("md_idle_hilo", 0, 0, 0, 0);
      clear_inputs();
   endtask

   task automatic test_md_err_reset();
      MD_Start = 1'b1;
      step("md2_start", 0, 0, 0, 0);
      MD_Start = 1'b0;
      for (int i = 0; i < 32; i++) begin
         MD_Start = (i == 4);
         step($sformatf("md2_busy_%0d", i), 0, 0, 1, i > 4);
      end
      MD_Start = 1'b1;
      step("md2_done_restart", 0, 0, 0, 1);
      MD_Start = 1'b0;
      for (int i = 0; i < 3; i++) step($sformatf("md3_busy_%0d", i), 0, 0, 1, 1);
      rst = 1'b1; MD_Start = 1'b1;
      step("md3_reset_cycle", 0, 0, 0, 1);
      rst = 1'b0; MD_Start = 1'b0;
      step("md3_after_reset", 0, 0, 0, 0);
      step("md3_no_done", 0, 0, 0, 0);
   endtask

   task automatic test_saturation();
      rst = 1'b1;
      step("sat_reset", 0, 0, 0, 0);
      rst = 1'b0;
      IDEX_MemRead = 1'b1; IDEX_RegRd = 5'd9; IFID_RegRs = 5'd9;
      for (int i = 0; i < 65540; i++)
         step($sformatf("sat_stall_%0d", i), 1, 0, 0, 0, (i < 3) || (i >= 65532));
      clear_inputs();
      step("sat_hold", 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      @(posedge clk);
      #1;
      test_reset();
      test_load_use();
      test_zero_reg();
      test_branch_alu();
      test_branch_load();
      test_md();
      test_md_err_reset();
      test_saturation();
      n_checks++;
      if (sb.size() != 0) begin
         n_fails++;
         $display("FAIL scoreboard_drain left %0d want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
